// File: rtl/timer_pkg.sv
// Shared types and default limits for the kitchen-timer controller.
// The state encoding lives here so the controller and any future observer agree on it.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_SEC_TENS_MAX = 5;
  localparam int DEF_DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with synchronous load and a parameterised wrap value.
// borrow flags that this enabled decrement wraps, so the next digit up must also step.
module bcd_down_digit #(
  parameter int MAX_VAL = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] value,
  output logic       borrow
);

  localparam logic [3:0] WRAP_VAL = 4'(MAX_VAL);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec_en) begin
      value <= (value == 4'd0) ? WRAP_VAL : value - 4'd1;
    end
  end

  assign borrow = dec_en && (value == 4'd0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: keypad entry in IDLE, BCD countdown in RUN, pause and done handling.
// Digits are three chained bcd_down_digit instances; heat_on and done are registered state decodes.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int SEC_TENS_MAX = DEF_SEC_TENS_MAX,
  parameter int DIGIT_MAX    = DEF_DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       heat_on,
  output logic       done
);

  state_t     state, state_next;
  logic       stop_prev;
  logic       stop_rise;
  logic       load_en;
  logic [3:0] ld_ones, ld_tens, ld_min;
  logic       dec_ones;
  logic       ones_borrow, tens_borrow, min_borrow;
  logic       time_zero, time_last, tens_ok, key_ok;

  assign stop_rise = stop_clear && !stop_prev;
  assign time_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign time_last = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign tens_ok   = sec_tens <= 4'(SEC_TENS_MAX);
  assign key_ok    = key_digit <= 4'd9;

  // A tick only counts in RUN when neither pause condition is present.
  assign dec_ones = (state == ST_RUN) && tick && !stop_clear && door_closed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      stop_prev <= 1'b0;
      heat_on   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      stop_prev <= stop_clear;
      heat_on   <= (state_next == ST_RUN);
      done      <= (state_next == ST_DONE);
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    ld_ones    = 4'd0;
    ld_tens    = 4'd0;
    ld_min     = 4'd0;
    case (state)
      ST_IDLE: begin
        if (stop_clear) begin
          load_en = 1'b1;
        end else if (start && door_closed && !time_zero && tens_ok) begin
          state_next = ST_RUN;
        end else if (key_valid && key_ok) begin
          load_en = 1'b1;
          ld_ones = key_digit;
          ld_tens = sec_ones;
          ld_min  = sec_tens;
        end
      end
      ST_RUN: begin
        if (stop_clear || !door_closed) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          if (time_last) begin
            state_next = ST_DONE;
          end else if (min_borrow) begin
            // Underflow is unreachable from legal entry; park at 0:00 rather than wrap.
            state_next = ST_DONE;
            load_en    = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        // Edge-detected so a stop_clear held from RUN only pauses, never clears.
        if (stop_rise) begin
          state_next = ST_IDLE;
          load_en    = 1'b1;
        end else if (start && door_closed) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start || stop_clear || key_valid) begin
          state_next = ST_IDLE;
          load_en    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_sec_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (ld_ones),
    .dec_en   (dec_ones),
    .value    (sec_ones),
    .borrow   (ones_borrow)
  );

  bcd_down_digit #(.MAX_VAL(SEC_TENS_MAX)) u_sec_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (ld_tens),
    .dec_en   (ones_borrow),
    .value    (sec_tens),
    .borrow   (tens_borrow)
  );

  bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_min_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (ld_min),
    .dec_en   (tens_borrow),
    .value    (min_ones),
    .borrow   (min_borrow)
  );

endmodule
